// File: rtl/coproc_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : coproc_host_bridge
// Purpose  : Host-side front end for the 5x5 matrix coprocessor. Takes a
//            command word and two packed operand matrices (7 words each) from
//            the host, drives the coprocessor, waits for its done flag under
//            a timeout, then streams the 200-bit result back as 7 words.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            abort               - synchronous return to IDLE
//            wr_valid/wr_data/wr_ready - host write stream (command + operands)
//            rd_valid/rd_data/rd_ready - host read stream (result)
//            cp_*                - coprocessor operand/result interface
//            busy, error         - status (error is a sticky timeout flag)
// Revision : 1.0 - initial release
// ============================================================================
module coproc_host_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         wr_valid,
  input  logic [31:0]  wr_data,
  output logic         wr_ready,
  output logic         rd_valid,
  output logic [31:0]  rd_data,
  input  logic         rd_ready,
  output logic [2:0]   cp_op_code,
  output logic [1:0]   cp_matrix_size,
  output logic [199:0] cp_matrix_a,
  output logic [199:0] cp_matrix_b,
  input  logic         cp_process_done,
  input  logic [199:0] cp_result,
  output logic         busy,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT   = 3'd3,
    S_SEND   = 3'd4
  } state_t;

  localparam logic [15:0] c_timer_last = 16'(TIMEOUT_CYCLES - 1);

  state_t         state_q, state_d;
  logic [2:0]     word_cnt_q, word_cnt_d;
  logic [15:0]    timer_q, timer_d;
  logic [2:0]     op_q, op_d;
  logic [1:0]     size_q, size_d;
  logic [199:0]   mat_a_q, mat_a_d;
  logic [199:0]   mat_b_q, mat_b_d;
  logic [199:0]   result_q, result_d;
  logic           error_q, error_d;

  logic           w_wr_fire;
  logic           w_rd_fire;

  // Overwrite transfer word idx of a packed matrix. Word 6 only carries
  // element 24, so the upper 24 bits of that host word are dropped.
  function automatic logic [199:0] merge_word(input logic [199:0] m,
                                              input logic [2:0]   idx,
                                              input logic [31:0]  w);
    logic [199:0] r;
    r = m;
    case (idx)
      3'd0: r[31:0]    = w;
      3'd1: r[63:32]   = w;
      3'd2: r[95:64]   = w;
      3'd3: r[127:96]  = w;
      3'd4: r[159:128] = w;
      3'd5: r[191:160] = w;
      3'd6: r[199:192] = w[7:0];
      default: r = m;
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake and status outputs (decoded from state only)
  // --------------------------------------------------------------------------
  assign wr_ready  = (state_q == S_IDLE) || (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign rd_valid  = (state_q == S_SEND);
  assign busy      = (state_q != S_IDLE);
  assign w_wr_fire = wr_valid && wr_ready;
  assign w_rd_fire = rd_valid && rd_ready;

  // The coprocessor is combinational: a zero op_code keeps it idle with done
  // low, so the latched op_code is only exposed while waiting for it.
  assign cp_op_code     = (state_q == S_WAIT) ? op_q : 3'b000;
  assign cp_matrix_size = size_q;
  assign cp_matrix_a    = mat_a_q;
  assign cp_matrix_b    = mat_b_q;
  assign error          = error_q;

  // Result word select; word 6 carries element 24 zero-extended.
  always_comb begin
    rd_data = 32'd0;
    if (state_q == S_SEND) begin
      case (word_cnt_q)
        3'd0: rd_data = result_q[31:0];
        3'd1: rd_data = result_q[63:32];
        3'd2: rd_data = result_q[95:64];
        3'd3: rd_data = result_q[127:96];
        3'd4: rd_data = result_q[159:128];
        3'd5: rd_data = result_q[191:160];
        3'd6: rd_data = {24'd0, result_q[199:192]};
        default: rd_data = 32'd0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    timer_d    = timer_q;
    op_d       = op_q;
    size_d     = size_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;
    result_d   = result_q;
    error_d    = error_q;

    if (abort) begin
      // Abort wins over any transfer this cycle; loaded words and error stay.
      state_d    = S_IDLE;
      word_cnt_d = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_wr_fire) begin
            op_d       = wr_data[2:0];
            size_d     = wr_data[4:3];
            error_d    = 1'b0;
            word_cnt_d = 3'd0;
            state_d    = S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          if (w_wr_fire) begin
            mat_a_d = merge_word(mat_a_q, word_cnt_q, wr_data);
            if (word_cnt_q == 3'd6) begin
              word_cnt_d = 3'd0;
              state_d    = S_LOAD_B;
            end else begin
              word_cnt_d = word_cnt_q + 3'd1;
            end
          end
        end
        S_LOAD_B: begin
          if (w_wr_fire) begin
            mat_b_d = merge_word(mat_b_q, word_cnt_q, wr_data);
            if (word_cnt_q == 3'd6) begin
              word_cnt_d = 3'd0;
              timer_d    = 16'd0;
              state_d    = S_WAIT;
            end else begin
              word_cnt_d = word_cnt_q + 3'd1;
            end
          end
        end
        S_WAIT: begin
          if (cp_process_done) begin
            result_d = cp_result;
            state_d  = S_SEND;
          end else if (timer_q == c_timer_last) begin
            // Timeout still produces a full zero result so the host read
            // sequence is the same on both paths.
            result_d = 200'd0;
            error_d  = 1'b1;
            state_d  = S_SEND;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_SEND: begin
          if (w_rd_fire) begin
            if (word_cnt_q == 3'd6) begin
              word_cnt_d = 3'd0;
              state_d    = S_IDLE;
            end else begin
              word_cnt_d = word_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_d    = S_IDLE;
          word_cnt_d = 3'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= 3'd0;
      timer_q    <= 16'd0;
      op_q       <= 3'd0;
      size_q     <= 2'd0;
      mat_a_q    <= 200'd0;
      mat_b_q    <= 200'd0;
      result_q   <= 200'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      timer_q    <= timer_d;
      op_q       <= op_d;
      size_q     <= size_d;
      mat_a_q    <= mat_a_d;
      mat_b_q    <= mat_b_d;
      result_q   <= result_d;
      error_q    <= error_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coproc_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_coproc_host_bridge
// Purpose  : Self-checking bench for coproc_host_bridge. A combinational
//            coprocessor stub (result = A ^ B, done when op_code == 7) sits on
//            the coprocessor side; expected results are computed element by
//            element from the host words held in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coproc_host_bridge;

  logic         clk;
  logic         rst_n;
  logic         abort;
  logic         wr_valid;
  logic [31:0]  wr_data;
  logic         wr_ready;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         rd_ready;
  logic [2:0]   cp_op_code;
  logic [1:0]   cp_matrix_size;
  logic [199:0] cp_matrix_a;
  logic [199:0] cp_matrix_b;
  logic         cp_process_done;
  logic [199:0] cp_result;
  logic         busy;
  logic         error;

  int n_cmp;
  int n_fail;

  // Host-side words of the current transaction and the expected read words.
  logic [31:0] a_w [7];
  logic [31:0] b_w [7];
  logic [31:0] exp_w [7];

  coproc_host_bridge #(.TIMEOUT_CYCLES(255)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .abort           (abort),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .rd_ready        (rd_ready),
    .cp_op_code      (cp_op_code),
    .cp_matrix_size  (cp_matrix_size),
    .cp_matrix_a     (cp_matrix_a),
    .cp_matrix_b     (cp_matrix_b),
    .cp_process_done (cp_process_done),
    .cp_result       (cp_result),
    .busy            (busy),
    .error           (error)
  );

  // Coprocessor stub
  assign cp_result       = cp_matrix_a ^ cp_matrix_b;
  assign cp_process_done = (cp_op_code == 3'b111);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model --
  function automatic logic [7:0] elem_a(input int i);
    logic [31:0] w;
    w = a_w[i / 4];
    return w[8 * (i % 4) +: 8];
  endfunction

  function automatic logic [7:0] elem_b(input int i);
    logic [31:0] w;
    w = b_w[i / 4];
    return w[8 * (i % 4) +: 8];
  endfunction

  function automatic logic [199:0] pack_a();
    logic [199:0] r;
    for (int i = 0; i < 25; i++) r[8 * i +: 8] = elem_a(i);
    return r;
  endfunction

  function automatic logic [199:0] pack_b();
    logic [199:0] r;
    for (int i = 0; i < 25; i++) r[8 * i +: 8] = elem_b(i);
    return r;
  endfunction

  // ok=1: element-wise XOR result; ok=0: timeout, all words zero.
  task automatic build_expected(input bit ok);
    for (int k = 0; k < 7; k++) begin
      exp_w[k] = 32'd0;
      for (int j = 0; j < 4; j++) begin
        if (ok && (4 * k + j) < 25)
          exp_w[k][8 * j +: 8] = elem_a(4 * k + j) ^ elem_b(4 * k + j);
      end
    end
  endtask

  task automatic fill_const(input logic [31:0] av, input logic [31:0] bv);
    for (int k = 0; k < 7; k++) begin
      a_w[k] = av;
      b_w[k] = bv;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 7; k++) begin
      a_w[k] = $urandom;
      b_w[k] = $urandom;
    end
  endtask

  // -------------------------------------------------------------- drivers --
  task automatic write_word(input logic [31:0] d);
    int guard;
    wr_valid = 1'b1;
    wr_data  = d;
    guard    = 0;
    while (wr_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL write_ready_timeout got wr_ready=%b want 1", wr_ready);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_data  = $urandom;
  endtask

  task automatic load_txn(input logic [31:0] cmd);
    write_word(cmd);
    for (int k = 0; k < 7; k++) write_word(a_w[k]);
    for (int k = 0; k < 7; k++) write_word(b_w[k]);
  endtask

  // Reads 7 words, holding rd_ready low for 'hold' cycles on each word.
  task automatic read_all(input int hold, input string tag);
    logic [31:0] snap;
    int guard;
    for (int k = 0; k < 7; k++) begin
      guard = 0;
      while (rd_valid !== 1'b1 && guard < 400) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 400) begin
        n_cmp++; n_fail++;
        $display("FAIL %s_rd_valid_timeout word %0d got rd_valid=%b want 1", tag, k, rd_valid);
        rd_ready = 1'b0;
        return;
      end
      if (hold > 0) begin
        rd_ready = 1'b0;
        snap     = rd_data;
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          n_cmp++;
          if (rd_data !== snap || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_hold word %0d got %h/%b want %h/1", tag, k, rd_data, rd_valid, snap);
          end
        end
      end
      rd_ready = 1'b1;
      n_cmp++;
      if (rd_data !== exp_w[k]) begin
        n_fail++;
        $display("FAIL %s_word%0d got %h want %h", tag, k, rd_data, exp_w[k]);
      end
      @(posedge clk); #1;
      if (hold > 0) rd_ready = 1'b0;
    end
    rd_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_return_idle got busy=%b rd_valid=%b want 0/0", tag, busy, rd_valid);
    end
  endtask

  // ---------------------------------------------------------------- tests --
  task automatic test_reset();
    rst_n = 1'b0;
    #22;
    n_cmp++;
    if ({wr_ready, rd_valid, busy, error} !== 4'b1000 || rd_data !== 32'd0 ||
        cp_op_code !== 3'd0 || cp_matrix_size !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b rv=%b busy=%b err=%b rd=%h op=%h sz=%h want 1 0 0 0 0 0 0",
               wr_ready, rd_valid, busy, error, rd_data, cp_op_code, cp_matrix_size);
    end
    n_cmp++;
    if (cp_matrix_a !== 200'd0 || cp_matrix_b !== 200'd0) begin
      n_fail++;
      $display("FAIL reset_matrices got a=%h b=%h want 0", cp_matrix_a, cp_matrix_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got wr_ready=%b busy=%b want 1/0", wr_ready, busy);
    end
  endtask

  task automatic test_basic();
    fill_const(32'h01010101, 32'h02020202);
    build_expected(1'b1);
    load_txn(32'h0000001F);
    n_cmp++;
    if (rd_valid !== 1'b0 || busy !== 1'b1 || cp_op_code !== 3'd7) begin
      n_fail++;
      $display("FAIL basic_wait_cycle got rd_valid=%b busy=%b op=%h want 0/1/7", rd_valid, busy, cp_op_code);
    end
    n_cmp++;
    if (cp_matrix_size !== 2'd3 || cp_matrix_a !== pack_a() || cp_matrix_b !== pack_b()) begin
      n_fail++;
      $display("FAIL basic_operands got size=%h a=%h want size=3 a=%h", cp_matrix_size, cp_matrix_a, pack_a());
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rd_valid !== 1'b1 || cp_op_code !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_latency got rd_valid=%b op=%h want 1/0", rd_valid, cp_op_code);
    end
    n_cmp++;
    if (exp_w[0] !== 32'h03030303 || exp_w[6] !== 32'h00000003) begin
      n_fail++;
      $display("FAIL basic_model got w0=%h w6=%h want 03030303/00000003", exp_w[0], exp_w[6]);
    end
    read_all(0, "basic");
    n_cmp++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_error got %b want 0", error);
    end
  endtask

  task automatic test_backpressure();
    fill_const(32'h01010101, 32'h02020202);
    build_expected(1'b1);
    load_txn(32'h0000001F);
    read_all(3, "bp");
  endtask

  task automatic test_timeout();
    int cycles;
    logic [199:0] a_hold;
    fill_random();
    build_expected(1'b0);
    load_txn(32'h00000001);
    a_hold = pack_a();
    // A write held valid while waiting must not be taken.
    wr_valid = 1'b1;
    wr_data  = $urandom;
    cycles   = 0;
    n_cmp++;
    if (cp_op_code !== 3'd1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL to_wait_drive got op=%h wr_ready=%b want 1/0", cp_op_code, wr_ready);
    end
    while (rd_valid !== 1'b1 && cycles < 1000) begin
      cycles++;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    n_cmp++;
    if (cycles !== 255) begin
      n_fail++;
      $display("FAIL to_wait_length got %0d want 255", cycles);
    end
    n_cmp++;
    if (error !== 1'b1 || cp_matrix_a !== a_hold) begin
      n_fail++;
      $display("FAIL to_error_or_a got err=%b a=%h want 1 a=%h", error, cp_matrix_a, a_hold);
    end
    read_all(1, "to");
    // abort in IDLE leaves the sticky flag alone
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL to_abort_keeps_error got %b want 1", error);
    end
    write_word(32'hFFFFFFE7);
    n_cmp++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL to_cmd_clears_error got err=%b busy=%b want 0/1", error, busy);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic test_abort();
    logic [199:0] b_part;
    fill_random();
    write_word(32'h0000001F);
    for (int k = 0; k < 7; k++) write_word(a_w[k]);
    for (int k = 0; k < 3; k++) write_word(b_w[k]);
    b_part = cp_matrix_b;
    // abort coincides with a valid write: the write must be dropped
    abort    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'hDEADBEEF;
    @(posedge clk); #1;
    abort    = 1'b0;
    wr_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || wr_ready !== 1'b1 || cp_matrix_b !== b_part) begin
      n_fail++;
      $display("FAIL abort_to_idle got busy=%b rdy=%b b=%h want 0/1 b=%h", busy, wr_ready, cp_matrix_b, b_part);
    end
    n_cmp++;
    if (cp_matrix_a !== pack_a()) begin
      n_fail++;
      $display("FAIL abort_keeps_a got %h want %h", cp_matrix_a, pack_a());
    end
    abort    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'h0000001F;
    @(posedge clk); #1;
    abort    = 1'b0;
    wr_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle_cmd got busy=%b want 0", busy);
    end
    fill_random();
    build_expected(1'b1);
    load_txn(32'h00000017);
    read_all(0, "abort_fresh");
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [1:0] sz;
    for (int t = 0; t < 5; t++) begin
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 6)) : 3'd7;
      sz = 2'($urandom_range(0, 3));
      fill_random();
      build_expected(op == 3'd7);
      load_txn({$urandom_range(0, 32'h07FFFFFF), sz, op} & 32'hFFFFFFFF);
      n_cmp++;
      if (cp_matrix_size !== sz || cp_matrix_a !== pack_a() || cp_matrix_b !== pack_b()) begin
        n_fail++;
        $display("FAIL rnd%0d_operands got size=%h want %h", t, cp_matrix_size, sz);
      end
      read_all($urandom_range(0, 2), "rnd");
      n_cmp++;
      if (error !== (op != 3'd7)) begin
        n_fail++;
        $display("FAIL rnd%0d_error got %b want %b", t, error, (op != 3'd7));
      end
    end
  endtask

  task automatic test_reset_mid_send();
    int seen;
    int guard;
    fill_random();
    build_expected(1'b1);
    load_txn(32'h0000000F);
    guard = 0;
    while (rd_valid !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (rd_data !== exp_w[k]) begin
        n_fail++;
        $display("FAIL mid_word%0d got %h want %h", k, rd_data, exp_w[k]);
      end
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 32'd0 || wr_ready !== 1'b1 ||
        cp_matrix_a !== 200'd0 || cp_matrix_b !== 200'd0 || cp_matrix_size !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset_values got rv=%b busy=%b rd=%h rdy=%b want 0 0 0 1 and zero matrices",
               rd_valid, busy, rd_data, wr_ready);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    rd_ready = 1'b1;
    seen     = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (rd_valid === 1'b1) seen++;
    end
    rd_ready = 1'b0;
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL mid_no_rd_valid got %0d cycles want 0", seen);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    abort    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 32'd0;
    rd_ready = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_abort();
    test_random();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coproc_host_bridge.md
Name: coproc_host_bridge

Overview:
Host-side front end for the matrix coprocessor, driving the end of the interface that the coprocessor consumes.
- Accepts a command word and two packed 5x5 operand matrices as a stream of 32-bit words from the HPS over a valid/ready handshake.
- Presents op_code, size and operands to the coprocessor, then waits for its done flag with a timeout.
- Latches the 200-bit result and streams it back to the host as 32-bit words over a second valid/ready handshake.

Parameters:
TIMEOUT_CYCLES, 255, maximum WAIT cycles without cp_process_done before the error path is taken (range 1..65535).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous abort: return to IDLE from any state
wr_valid  in  1  host word valid
wr_data  in  32  host word
wr_ready  out  1  bridge accepts wr_data this cycle
rd_valid  out  1  result word valid
rd_data  out  32  result word
rd_ready  in  1  host accepts rd_data this cycle
cp_op_code  out  3  op_code to coprocessor
cp_matrix_size  out  2  matrix_size to coprocessor (0=2x2, 1=3x3, 2=4x4, 3=5x5)
cp_matrix_a  out  200  operand A to coprocessor
cp_matrix_b  out  200  operand B to coprocessor
cp_process_done  in  1  coprocessor done flag
cp_result  in  200  coprocessor result
busy  out  1  high in every state except IDLE
error  out  1  sticky timeout flag

Behaviour:
Data format
- Matrix: 25 signed 8-bit elements, row-major; element i occupies bits [8i+7:8i]. Unused elements for sizes below 5x5 are passed through unchanged; the bridge does not interpret them.
- Matrix transfer: 7 words. Word k, byte j (bits [8j+7:8j]) carries element 4k+j.
  - Word 6 carries only element 24 in bits [7:0]; bits [31:8] are ignored on write and driven 0 on read.
- Command word: [2:0] op_code, [4:3] matrix_size; bits [31:5] ignored.

Handshake
- A transfer occurs on a rising edge where valid and ready are both high.
- wr_ready = 1 in IDLE, LOAD_A and LOAD_B; 0 otherwise.
- rd_valid = 1 only in SEND.
- rd_data is stable while rd_valid=1 and rd_ready=0.

State machine
- IDLE
  - On a write transfer: latch op_code and size, clear error, word_cnt<=0, go to LOAD_A.
- LOAD_A
  - Each write transfer stores word word_cnt into matrix_a and increments word_cnt.
  - The transfer at word_cnt=6 resets word_cnt to 0 and goes to LOAD_B.
- LOAD_B
  - Same as LOAD_A, writing matrix_b.
  - The transfer at word_cnt=6 clears timer and goes to WAIT.
- WAIT
  - cp_op_code = latched op_code.
  - If cp_process_done=1: result_reg<=cp_result, go to SEND.
  - Else if timer == TIMEOUT_CYCLES-1: result_reg<=0, error<=1, go to SEND.
  - Otherwise timer increments.
- SEND
  - rd_data = word word_cnt of result_reg.
  - Each read transfer increments word_cnt; the transfer at word_cnt=6 goes to IDLE.

Coprocessor drive
- cp_op_code = 3'b000 in every state except WAIT, which keeps the combinational coprocessor idle and done low.
- cp_matrix_a, cp_matrix_b and cp_matrix_size are registered and hold their values until overwritten.

Latency
- With a combinational coprocessor: last B-word transfer at edge N, WAIT during cycle N+1, result latched at edge N+1, rd_valid high from cycle N+2.

Boundary conditions
- A write held valid outside a load state is not accepted.
- A done flag seen outside WAIT is ignored.
- abort has priority over every transfer in the same cycle.
  - abort forces IDLE and word_cnt<=0; the matrices keep any words already written.
  - abort leaves error unchanged.
- A timeout still returns exactly 7 words, all zero, so the host protocol is uniform.

Reset values (rst_n low, asynchronous)
- State IDLE; word_cnt and timer 0.
- Outputs: wr_ready=1, rd_valid=0, rd_data=0, busy=0, error=0, cp_op_code=0, cp_matrix_size=0, cp_matrix_a=0, cp_matrix_b=0.
- result_reg=0.

Test Plan:
Bench stub for the coprocessor: cp_result = cp_matrix_a ^ cp_matrix_b; cp_process_done = (cp_op_code == 3'b111).
1. Release rst_n -> all outputs at reset values; wr_ready=1; busy=0.
2. Command 0x0000001F (op=7, size=3); A words all 0x01010101; B words all 0x02020202; rd_ready=1.
   -> rd_valid rises 2 cycles after the last B transfer.
   -> Words 0..5 = 0x03030303, word 6 = 0x00000003; error=0; returns to IDLE.
3. Repeat scenario 2 with rd_ready low for 3 cycles on every word -> rd_data held stable, no word lost or duplicated, same 7 values.
4. Command op=3'b001 -> done never rises; WAIT lasts exactly 255 cycles; error=1; 7 zero words.
   -> Next valid command clears error.
5. abort asserted after 3 B words -> IDLE next cycle, busy=0.
   -> A fresh full transaction then produces the correct result.
6. rst_n pulsed low mid-SEND (word 3) -> immediate return to reset values; no further rd_valid.
